// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with an elastic
// valid/ready pipeline of STAGES register stages and a sideband tag.
// The format is either given explicitly or auto-decoded from the opcode.
// Optional macro IMM_ERR_EN adds out_err (illegal word flag) and err_cnt
// (saturating count of illegal words delivered).
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAGW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAGW-1:0]  out_tag
`ifdef IMM_ERR_EN
    ,
    output logic             out_err,
    output logic [7:0]       err_cnt
`endif
);

    localparam logic [2:0] FMT_ILL  = 3'b000;
    localparam logic [2:0] FMT_U    = 3'b001;
    localparam logic [2:0] FMT_I    = 3'b010;
    localparam logic [2:0] FMT_SH   = 3'b011;
    localparam logic [2:0] FMT_B    = 3'b100;
    localparam logic [2:0] FMT_S    = 3'b101;
    localparam logic [2:0] FMT_J    = 3'b110;
    localparam logic [2:0] SEL_AUTO = 3'b111;

    // Explicit selects pass through (000 is already illegal); 111 decodes the opcode.
    function automatic logic [2:0] resolve_fmt(input logic [2:0] sel, input logic [31:0] instr);
        logic [2:0] f;
        f = FMT_ILL;
        if (sel != SEL_AUTO) begin
            f = sel;
        end else begin
            case (instr[6:0])
                7'b0110111, 7'b0010111: f = FMT_U;
                7'b0000011, 7'b1100111: f = FMT_I;
                7'b0010011: f = (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) ? FMT_SH : FMT_I;
                7'b1100011: f = FMT_B;
                7'b0100011: f = FMT_S;
                7'b1101111: f = FMT_J;
                default:    f = FMT_ILL;
            endcase
        end
        return f;
    endfunction

    // Builds a 32-bit signed immediate, then sign-extends it to XLEN.
    // shamt is always non-negative, so sign extension doubles as zero extension.
    function automatic logic signed [XLEN-1:0] build_imm(input logic [2:0] fmt, input logic [31:0] instr);
        logic signed [31:0] raw;
        raw = '0;
        case (fmt)
            FMT_U:  raw = {instr[31:12], 12'b0};
            FMT_I:  raw = {{20{instr[31]}}, instr[31:20]};
            FMT_SH: raw = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
            FMT_B:  raw = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_S:  raw = {{21{instr[31]}}, instr[30:25], instr[11:7]};
            FMT_J:  raw = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: raw = '0;
        endcase
        return XLEN'(raw);
    endfunction

    logic [2:0]             in_fmt;
    logic signed [XLEN-1:0] in_imm;

    logic [STAGES-1:0]      vld_p;
    logic [STAGES-1:0]      ld;
    logic [XLEN-1:0]        imm_p [STAGES];
    logic [2:0]             fmt_p [STAGES];
    logic [TAGW-1:0]        tag_p [STAGES];

    // Format resolution and immediate construction ahead of stage 0.
    always_comb begin
        in_fmt = resolve_fmt(in_sel, in_instr);
        in_imm = build_imm(in_fmt, in_instr);
    end

    // Stage k can load when the consumer is ready or any stage from k to the
    // output is empty; written flat so the ready chain has no recursive net.
    always_comb begin
        ld = '0;
        for (int k = 0; k < STAGES; k++) begin
            ld[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!vld_p[j]) ld[k] = 1'b1;
            end
        end
    end

    assign in_ready = ld[0];

    // Stage registers: stage 0 takes the decoded input, stage k takes stage k-1.
    // Data only moves with a valid word so stalled outputs stay put.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
                imm_p[k] <= '0;
                fmt_p[k] <= '0;
                tag_p[k] <= '0;
            end
        end else begin
            // stage 0 boundary
            if (ld[0]) begin
                vld_p[0] <= in_valid;
                if (in_valid) begin
                    imm_p[0] <= in_imm;
                    fmt_p[0] <= in_fmt;
                    tag_p[0] <= in_tag;
                end
            end
            // stage 1..STAGES-1 boundaries
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) begin
                    vld_p[k] <= vld_p[k-1];
                    if (vld_p[k-1]) begin
                        imm_p[k] <= imm_p[k-1];
                        fmt_p[k] <= fmt_p[k-1];
                        tag_p[k] <= tag_p[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = vld_p[STAGES-1];
    assign out_imm   = imm_p[STAGES-1];
    assign out_fmt   = fmt_p[STAGES-1];
    assign out_tag   = tag_p[STAGES-1];

`ifdef IMM_ERR_EN
    assign out_err = out_valid && (out_fmt == FMT_ILL);

    // Saturating count of illegal words handed to the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (out_valid && out_ready && out_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: two instances (XLEN 32 and 64,
// both STAGES=2) share stimulus. Directed table, backpressure and reset
// sequences, then randomized traffic against a behavioural model.
module tb_imm_gen_pipe;

    localparam int ST = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_sel;
    logic [3:0]  in_tag;
    logic        out_ready;

    logic        rdy32, ov32, rdy64, ov64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;
    logic [3:0]  tag32, tag64;
`ifdef IMM_ERR_EN
    logic        err32, err64;
    logic [7:0]  cnt32, cnt64;
    int          exp_err;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .STAGES(ST), .TAGW(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
        .out_fmt(fmt32), .out_tag(tag32)
`ifdef IMM_ERR_EN
        , .out_err(err32), .err_cnt(cnt32)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(ST), .TAGW(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
        .out_fmt(fmt64), .out_tag(tag64)
`ifdef IMM_ERR_EN
        , .out_err(err64), .err_cnt(cnt64)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: format from the select/opcode rules.
    function automatic logic [2:0] ref_fmt(input logic [2:0] sel, input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        if (sel != 3'd7) return sel;
        if (op == 7'h37 || op == 7'h17) return 3'd1;
        if (op == 7'h03 || op == 7'h67) return 3'd2;
        if (op == 7'h13) return (f3 == 3'd1 || f3 == 3'd5) ? 3'd3 : 3'd2;
        if (op == 7'h63) return 3'd4;
        if (op == 7'h23) return 3'd5;
        if (op == 7'h6F) return 3'd6;
        return 3'd0;
    endfunction

    // Behavioural model: immediate value as a signed integer built from weighted fields.
    function automatic logic [63:0] ref_imm(input logic [2:0] f, input logic [31:0] w, input int xlen);
        longint v;
        longint s;
        v = 0;
        s = longint'(w[31]);
        case (f)
            3'd1: v = longint'(w[31:12]) * 4096 - s * (longint'(1) << 32);
            3'd2: v = longint'(w[31:20]) - s * 4096;
            3'd3: v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            3'd4: v = s * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                      + longint'(w[11:8]) * 2 - s * 8192;
            3'd5: v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - s * 4096;
            3'd6: v = s * (longint'(1) << 20) + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                      + longint'(w[30:21]) * 2 - s * (longint'(1) << 21);
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] instr;
        logic [63:0] e64;
        logic [31:0] e32;
        logic [2:0]  efmt;
    } vec_t;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] instr;
        logic [3:0]  tag;
    } wd_t;

    vec_t tbl [15];
    wd_t  q [$];

    logic        prev_stall = 1'b0;
    logic [31:0] p_imm32;
    logic [63:0] p_imm64;
    logic [2:0]  p_fmt;
    logic [3:0]  p_tag;

    // Samples one cycle of random traffic: scoreboard push/pop and stall stability.
    task automatic observe();
        wd_t         e;
        logic [2:0]  ef;
        logic [63:0] x64;
        logic [63:0] x32;
        chk("in_ready_match", {63'b0, rdy64}, {63'b0, rdy32});
        chk("out_valid_match", {63'b0, ov64}, {63'b0, ov32});
`ifdef IMM_ERR_EN
        chk("err_cnt32", {56'b0, cnt32}, 64'(exp_err));
        chk("err_cnt64", {56'b0, cnt64}, 64'(exp_err));
`endif
        if (in_valid && rdy32) q.push_back('{sel: in_sel, instr: in_instr, tag: in_tag});
        if (prev_stall) begin
            chk("hold_valid", {63'b0, ov32}, 64'd1);
            chk("hold_imm64", imm64, p_imm64);
            chk("hold_imm32", {32'b0, imm32}, {32'b0, p_imm32});
            chk("hold_fmt", {61'b0, fmt32}, {61'b0, p_fmt});
            chk("hold_tag", {60'b0, tag32}, {60'b0, p_tag});
        end
        if (ov32 && out_ready) begin
            if (q.size() == 0) begin
                chk("extra_word", 64'd1, 64'd0);
            end else begin
                e   = q.pop_front();
                ef  = ref_fmt(e.sel, e.instr);
                x64 = ref_imm(ef, e.instr, 64);
                x32 = ref_imm(ef, e.instr, 32);
                chk("rnd_imm64", imm64, x64);
                chk("rnd_imm32", {32'b0, imm32}, {32'b0, x32[31:0]});
                chk("rnd_fmt64", {61'b0, fmt64}, {61'b0, ef});
                chk("rnd_fmt32", {61'b0, fmt32}, {61'b0, ef});
                chk("rnd_tag", {60'b0, tag32}, {60'b0, e.tag});
`ifdef IMM_ERR_EN
                chk("rnd_err", {63'b0, err32}, {63'b0, (ef == 3'd0)});
                if (ef == 3'd0 && exp_err < 255) exp_err++;
`endif
            end
        end
        prev_stall = ov32 && !out_ready;
        p_imm32 = imm32;
        p_imm64 = imm64;
        p_fmt   = fmt32;
        p_tag   = tag32;
    endtask

    logic [6:0] ops [8];
    logic       seen;

    initial begin
        tbl[0]  = '{3'd2, 32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFF, 3'd2};
        tbl[1]  = '{3'd7, 32'hFFDFF06F, 64'hFFFFFFFF_FFFFFFFC, 32'hFFFFFFFC, 3'd6};
        tbl[2]  = '{3'd7, 32'h00000463, 64'h8, 32'h8, 3'd4};
        tbl[3]  = '{3'd7, 32'h03F01013, 64'h3F, 32'h1F, 3'd3};
        tbl[4]  = '{3'd0, 32'hFFFFFFFF, 64'h0, 32'h0, 3'd0};
        tbl[5]  = '{3'd7, 32'h0000007F, 64'h0, 32'h0, 3'd0};
        tbl[6]  = '{3'd1, 32'hDEADB037, 64'hFFFFFFFF_DEADB000, 32'hDEADB000, 3'd1};
        tbl[7]  = '{3'd7, 32'hFE000C23, 64'hFFFFFFFF_FFFFFFF8, 32'hFFFFFFF8, 3'd5};
        tbl[8]  = '{3'd7, 32'h12300093, 64'h123, 32'h123, 3'd2};
        tbl[9]  = '{3'd7, 32'h40515013, 64'h5, 32'h5, 3'd3};
        tbl[10] = '{3'd7, 32'h80002003, 64'hFFFFFFFF_FFFFF800, 32'hFFFFF800, 3'd2};
        tbl[11] = '{3'd7, 32'h00001017, 64'h1000, 32'h1000, 3'd1};
        tbl[12] = '{3'd7, 32'h00008067, 64'h0, 32'h0, 3'd2};
        tbl[13] = '{3'd3, 32'h02000013, 64'h20, 32'h0, 3'd3};
        tbl[14] = '{3'd4, 32'h0000047F, 64'h8, 32'h8, 3'd4};
        ops = '{7'h37, 7'h17, 7'h03, 7'h67, 7'h13, 7'h63, 7'h23, 7'h6F};

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_sel = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {63'b0, ov32}, 64'd0);
        chk("rst_in_ready", {63'b0, rdy32}, 64'd1);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_fmt", {61'b0, fmt64}, 64'd0);
        chk("rst_tag", {60'b0, tag64}, 64'd0);

        // Directed table: one word at a time, latency STAGES cycles.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_sel = tbl[i].sel; in_instr = tbl[i].instr; in_tag = 4'(i);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("tbl_early_valid", {63'b0, ov32}, 64'd0);
            @(negedge clk);
            #1;
            chk("tbl_valid", {63'b0, ov64}, 64'd1);
            chk("tbl_imm64", imm64, tbl[i].e64);
            chk("tbl_imm32", {32'b0, imm32}, {32'b0, tbl[i].e32});
            chk("tbl_fmt", {61'b0, fmt64}, {61'b0, tbl[i].efmt});
            chk("tbl_fmt32", {61'b0, fmt32}, {61'b0, tbl[i].efmt});
            chk("tbl_tag", {60'b0, tag64}, 64'(i));
`ifdef IMM_ERR_EN
            chk("tbl_err", {63'b0, err64}, {63'b0, (tbl[i].efmt == 3'd0)});
`endif
        end
        @(negedge clk);

        // Backpressure: tags 1,2 fill both stages, tag 3 held at the input.
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd2;
        in_tag = 4'd1; in_instr = {12'd100, 20'h00093};
        @(negedge clk);
        in_tag = 4'd2; in_instr = {12'd200, 20'h00093};
        @(negedge clk);
        in_tag = 4'd3; in_instr = {12'd300, 20'h00093};
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp_in_ready", {63'b0, rdy32}, 64'd0);
            chk("bp_out_tag", {60'b0, tag32}, 64'd1);
            chk("bp_out_imm", imm64, 64'd100);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {63'b0, rdy32}, 64'd1);
        chk("bp_first_tag", {60'b0, tag32}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_second_valid", {63'b0, ov32}, 64'd1);
        chk("bp_second_tag", {60'b0, tag32}, 64'd2);
        chk("bp_second_imm", {32'b0, imm32}, 64'd200);
        @(negedge clk);
        #1;
        chk("bp_third_valid", {63'b0, ov64}, 64'd1);
        chk("bp_third_tag", {60'b0, tag64}, 64'd3);
        chk("bp_third_imm", imm64, 64'd300);
        @(negedge clk);
        #1;
        chk("bp_drained", {63'b0, ov32}, 64'd0);

        // Reset mid-stream: two words in flight plus one presented during reset.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd2; in_tag = 4'd5;
        @(negedge clk);
        in_tag = 4'd6;
        @(negedge clk);
        rst = 1'b1; in_tag = 4'd7;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mrst_out_valid", {63'b0, ov32}, 64'd0);
        chk("mrst_in_ready", {63'b0, rdy32}, 64'd1);
        chk("mrst_imm", imm64, 64'd0);
        chk("mrst_tag", {60'b0, tag32}, 64'd0);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (ov32 || ov64) seen = 1'b1;
        end
        chk("mrst_no_emit", {63'b0, seen}, 64'd0);

        // Randomized traffic against the model.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef IMM_ERR_EN
        exp_err = 0;
`endif
        q.delete();
        prev_stall = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (c % 100 < 80) ? ($urandom_range(0, 3) != 0) : 1'b0;
            in_instr  = $urandom;
            if ($urandom_range(0, 3) != 0) in_instr[6:0] = ops[$urandom_range(0, 7)];
            in_sel    = ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            in_tag    = 4'($urandom);
            #1;
            observe();
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            observe();
        end
        chk("rnd_drained", 64'(q.size()), 64'd0);

`ifdef IMM_ERR_EN
        // Saturation: 300 illegal words with no backpressure.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; in_sel = 3'd0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        repeat (ST + 1) @(negedge clk);
        chk("err_two", {56'b0, cnt32}, 64'd2);
        in_valid = 1'b1;
        repeat (298) @(negedge clk);
        in_valid = 1'b0;
        repeat (ST + 2) @(negedge clk);
        chk("err_sat32", {56'b0, cnt32}, 64'd255);
        chk("err_sat64", {56'b0, cnt64}, 64'd255);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined RISC-V immediate generator. It replaces the single-cycle combinational sign-extender in the decode path.
- Accepts an instruction word with an explicit or auto-decoded format select.
- Produces the XLEN-wide sign-extended immediate through an elastic valid/ready pipeline of configurable depth.
- Carries a tag so the decode stage can match each result to its instruction.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64
STAGES, 1, number of register stages (latency); legal range 1..4
TAGW, 4, width of the sideband tag carried with each instruction

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input word valid
in_ready  output  1  pipeline can accept the input word this cycle
in_instr  input  32  instruction word
in_sel  input  3  format select: 001 U, 010 I/load, 011 shamt, 100 B, 101 S, 110 J, 111 auto-decode, 000 illegal
in_tag  input  TAGW  sideband tag
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_imm  output  XLEN  immediate
out_fmt  output  3  resolved format (001..110), or 000 if illegal
out_tag  output  TAGW  tag of the result

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Format resolution (combinational, ahead of stage 0): in_sel 001..110 is used directly; 000 resolves to illegal (fmt 000).
- Auto-decode (in_sel=111), by opcode in_instr[6:0]:
  - 0110111, 0010111 -> U
  - 0000011, 1100111 -> I
  - 0010011 -> shamt if funct3 in_instr[14:12] is 001 or 101, else I
  - 1100011 -> B
  - 0100011 -> S
  - 1101111 -> J
  - any other opcode -> illegal
- Immediate construction; every format is sign-extended from in_instr[31] to XLEN, except shamt:
  - U: {in[31:12], 12'b0}
  - I: in[31:20]
  - shamt: zero-extended; in[24:20] when XLEN=32, in[25:20] when XLEN=64
  - B: {in[31], in[7], in[30:25], in[11:8], 1'b0}
  - S: {in[31:25], in[11:7]}
  - J: {in[31], in[19:12], in[20], in[30:21], 1'b0}
  - illegal: out_imm = 0. Never drives X.
- Pipeline:
  - STAGES elastic stages. Each stage holds valid, imm, fmt and tag.
  - Stage k loads when it is empty or its contents advance this cycle. Stage STAGES-1 advances on out_ready.
  - in_ready = stage 0 can load. The ready chain is combinational.
  - A transfer occurs when in_valid && in_ready. The word appears on out_valid exactly STAGES cycles later if no backpressure.
  - Sustained throughput is one word per cycle.
- Handshake rules:
  - out_imm, out_fmt and out_tag are stable while out_valid && !out_ready.
  - out_valid never drops without a handshake.
  - Ordering is strictly FIFO. No loss and no duplication.
- Backpressure: when out_ready is low and all STAGES stages are full, in_ready=0. When out_ready returns high, in_ready=1 in the same cycle.
- Reset: when rst=1, every stage valid clears and out_imm, out_fmt, out_tag clear to 0.
  - The cycle after rst, out_valid=0 and in_ready=1.
  - Reset mid-stream discards all in-flight words. An input presented during reset is not captured.

Optional Feature:
Macro IMM_ERR_EN.
- Defined:
  - Adds output out_err (1 bit), high with out_valid when out_fmt=000.
  - Adds output err_cnt (8 bits): a saturating count of illegal words delivered. It increments on each out_valid && out_ready && out_err, holds at 255, and clears on rst.
- Undefined: neither port exists and illegal words are indicated only by out_fmt=000.

Test Plan:
1. STAGES=1, sel=010, instr=0xFFF00093 -> one cycle later out_imm=0xFFFFFFFF, out_fmt=010, out_tag preserved.
2. XLEN=64, STAGES=2, sel=111, instr=0xFFDFF06F (jal x0,-4) -> after 2 cycles out_imm=0xFFFFFFFFFFFFFFFC, out_fmt=110. Also sel=111, instr=0x00000463 (beq +8) -> out_imm=0x8, out_fmt=100.
3. XLEN=64, sel=111, instr=0x03F01013 (slli shamt 63) -> out_imm=0x3F, out_fmt=011. With XLEN=32, same instr -> out_imm=0x1F.
4. STAGES=2, out_ready=0 for 6 cycles, continuous in_valid with tags 1,2,3:
   - in_ready=0 after tags 1,2 are accepted, while tag 3 is held.
   - On release, outputs in the order 1,2,3 on consecutive cycles, with out_* stable during the stall.
5. sel=000 and sel=111 with opcode 0x7F -> out_imm=0, out_fmt=000.
   - With IMM_ERR_EN: out_err=1 and err_cnt increments per word. After 300 illegal words err_cnt=255.
6. STAGES=3, 2 words in flight, rst pulsed one cycle -> out_valid=0 the next cycle, neither word ever emitted, in_ready=1.
